// File: rtl/blake_pkg.sv
// Shared types and sizes for the blake host front end: state encoding and the
// header/digest geometry seen by the 64-bit streams.
package blake_pkg;

    localparam int WORD_W    = 64;
    localparam int IN_WORDS  = 10;
    localparam int OUT_WORDS = 8;
    localparam int HDR_W     = IN_WORDS * WORD_W;
    localparam int DIG_W     = OUT_WORDS * WORD_W;
    localparam int TIMEOUT   = 1023;
    localparam int TMO_W     = 10;
    localparam int WCNT_W    = 4;
    localparam int OCNT_W    = 3;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FIRE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/blake_digest_serializer.sv
// Holds a captured 512-bit digest and presents it as eight 64-bit words on a
// valid/ready stream, most significant word first; done pulses on the final handshake.
module blake_digest_serializer
    import blake_pkg::*;
(
    input  logic              clk,
    input  logic              rstb,
    input  logic              load_i,
    input  logic [DIG_W-1:0]  digest_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [WORD_W-1:0] m_data_o,
    output logic              m_last_o,
    output logic              done_o
);

    logic [DIG_W-1:0]  digest_q;
    logic [OCNT_W-1:0] idx_q;
    logic              valid_q;
    logic              xfer;
    logic              at_last;

    assign xfer    = valid_q & m_ready_i;
    assign at_last = (idx_q == OCNT_W'(OUT_WORDS - 1));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            digest_q <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
        end else if (load_i) begin
            digest_q <= digest_i;
            idx_q    <= '0;
            valid_q  <= 1'b1;
        end else if (xfer) begin
            if (at_last) begin
                idx_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Word select straight off the held digest so data stays put while stalled.
    always_comb begin
        m_data_o = '0;
        for (int j = 0; j < OUT_WORDS; j++) begin
            if (idx_q == OCNT_W'(j)) begin
                m_data_o = digest_q[DIG_W-1-WORD_W*j -: WORD_W];
            end
        end
    end

    assign m_valid_o = valid_q;
    assign m_last_o  = valid_q & at_last;
    assign done_o    = xfer & at_last;

endmodule

// File: rtl/blake_stream_host.sv
// Host front end for the blake core: assembles a 640-bit header from a 64-bit
// stream, starts the core, waits with a timeout and streams the digest back out.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_LOAD  | accepting header words, checking s_last against word position
// ST_FIRE  | one-cycle core_ena pulse, header held on core_din
// ST_WAIT  | waiting for core_rdy, timeout counter running
// ST_DRAIN | digest words streaming out on the m_* interface
module blake_stream_host
    import blake_pkg::*;
(
    input  logic              clk,
    input  logic              rstb,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_last,
    output logic [HDR_W-1:0]  core_din,
    output logic              core_ena,
    input  logic              core_rdy,
    input  logic [DIG_W-1:0]  core_dout,
    output logic              busy,
    output logic              err_frame,
    output logic              err_tmo
);

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [HDR_W-1:0]   core_din_q;
    logic               s_ready_q;
    logic               core_ena_q;
    logic               busy_q;
    logic               err_frame_q, err_frame_d;
    logic               err_tmo_q, err_tmo_d;
    logic               hdr_we;
    logic               dig_load;
    logic               dig_done;
    logic               accept;
    logic               last_pos;

    assign accept   = s_valid & s_ready_q;
    assign last_pos = (wcnt_q == WCNT_W'(IN_WORDS - 1));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= ST_LOAD;
            wcnt_q      <= '0;
            tmo_q       <= '0;
            s_ready_q   <= 1'b0;
            core_ena_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_frame_q <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            tmo_q       <= tmo_d;
            s_ready_q   <= (state_d == ST_LOAD);
            core_ena_q  <= (state_d == ST_FIRE);
            busy_q      <= (state_d != ST_LOAD);
            err_frame_q <= err_frame_d;
            err_tmo_q   <= err_tmo_d;
        end
    end

    // tmo counts WAIT cycles including the current one, so the abort lands on
    // WAIT cycle TIMEOUT and a core_rdy in that same cycle still wins.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        tmo_d       = tmo_q;
        hdr_we      = 1'b0;
        err_frame_d = 1'b0;
        err_tmo_d   = 1'b0;
        dig_load    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (s_last && last_pos) begin
                        hdr_we  = 1'b1;
                        wcnt_d  = '0;
                        state_d = ST_FIRE;
                    end else if (s_last || last_pos) begin
                        err_frame_d = 1'b1;
                        wcnt_d      = '0;
                    end else begin
                        hdr_we = 1'b1;
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            ST_FIRE: begin
                tmo_d   = TMO_W'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_rdy) begin
                    dig_load = 1'b1;
                    tmo_d    = '0;
                    state_d  = ST_DRAIN;
                end else if (tmo_q == TMO_W'(TIMEOUT)) begin
                    err_tmo_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = ST_LOAD;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (dig_done) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            core_din_q <= '0;
        end else if (hdr_we) begin
            for (int k = 0; k < IN_WORDS; k++) begin
                if (wcnt_q == WCNT_W'(k)) begin
                    core_din_q[HDR_W-1-WORD_W*k -: WORD_W] <= s_data;
                end
            end
        end
    end

    blake_digest_serializer u_ser (
        .clk       (clk),
        .rstb      (rstb),
        .load_i    (dig_load),
        .digest_i  (core_dout),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_data_o  (m_data),
        .m_last_o  (m_last),
        .done_o    (dig_done)
    );

    assign s_ready   = s_ready_q;
    assign core_din  = core_din_q;
    assign core_ena  = core_ena_q;
    assign busy      = busy_q;
    assign err_frame = err_frame_q;
    assign err_tmo   = err_tmo_q;

endmodule

// File: tb/tb_blake_stream_host.sv
// Directed bench for blake_stream_host with an inline stub core; inputs are driven
// and outputs sampled 2 time units after each rising edge.
module tb_blake_stream_host;

    logic           clk;
    logic           rstb;
    logic           s_valid;
    logic           s_ready;
    logic [63:0]    s_data;
    logic           s_last;
    logic           m_valid;
    logic           m_ready;
    logic [63:0]    m_data;
    logic           m_last;
    logic [639:0]   core_din;
    logic           core_ena;
    logic           core_rdy;
    logic [511:0]   core_dout;
    logic           busy;
    logic           err_frame;
    logic           err_tmo;

    int n_vec;
    int n_err;
    int ena_cnt;

    blake_stream_host dut (
        .clk       (clk),
        .rstb      (rstb),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .core_din  (core_din),
        .core_ena  (core_ena),
        .core_rdy  (core_rdy),
        .core_dout (core_dout),
        .busy      (busy),
        .err_frame (err_frame),
        .err_tmo   (err_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (core_ena === 1'b1) ena_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [511:0] mk_dig(input logic [63:0] base);
        logic [511:0] v;
        v = '0;
        for (int j = 0; j < 8; j++) v[511-64*j -: 64] = base + 64'(j);
        return v;
    endfunction

    task automatic send_word(input logic [63:0] d, input logic last);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (s_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (s_ready !== 1'b1) chk("s_ready_wait", 64'(s_ready), 64'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] base, input int nw, input int last_idx);
        for (int k = 0; k < nw; k++) send_word(base + 64'(k), k == last_idx);
    endtask

    task automatic check_din(input string tag, input logic [63:0] base);
        for (int k = 0; k < 10; k++) chk(tag, core_din[639-64*k -: 64], base + 64'(k));
    endtask

    // Called in the core_ena cycle; raises core_rdy 'delay' cycles later for one cycle.
    task automatic core_reply(input int delay, input logic [63:0] base);
        repeat (delay) tick();
        core_rdy  = 1'b1;
        core_dout = mk_dig(base);
        tick();
        core_rdy  = 1'b0;
    endtask

    task automatic drain(input string tag, input logic [63:0] base, input logic stall);
        logic [3:0] pat;
        int j;
        int c;
        pat = 4'b1001;
        j = 0;
        c = 0;
        while (j < 8 && c < 64) begin
            m_ready = stall ? pat[c % 4] : 1'b1;
            chk({tag, "_valid"}, 64'(m_valid), 64'd1);
            chk({tag, "_data"}, m_data, base + 64'(j));
            chk({tag, "_last"}, 64'(m_last), 64'(j == 7));
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            if (m_ready) j++;
            tick();
            c++;
        end
        if (j < 8) chk({tag, "_words"}, 64'(j), 64'd8);
        m_ready = 1'b1;
        chk({tag, "_end_valid"}, 64'(m_valid), 64'd0);
        chk({tag, "_end_busy"}, 64'(busy), 64'd0);
        chk({tag, "_end_ready"}, 64'(s_ready), 64'd1);
    endtask

    initial begin
        int e0;
        int n;
        n_vec     = 0;
        n_err     = 0;
        ena_cnt   = 0;
        rstb      = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_last    = 1'b0;
        m_ready   = 1'b1;
        core_rdy  = 1'b0;
        core_dout = '0;
        tick();
        tick();

        // reset values
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_core_ena", 64'(core_ena), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_din0", core_din[639 -: 64], 64'd0);
        chk("rst_err", {62'd0, err_frame, err_tmo}, 64'd0);
        rstb = 1'b1;
        tick();
        chk("post_rst_s_ready", 64'(s_ready), 64'd1);

        // frame 0..9, stub replies 5 cycles after ena with A0..A7, full-rate drain
        e0 = ena_cnt;
        send_frame(64'h0, 10, 9);
        chk("t1_ena", 64'(core_ena), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_s_ready", 64'(s_ready), 64'd0);
        check_din("t1_din", 64'h0);
        core_reply(5, 64'hA0);
        chk("t1_ena_once", 64'(ena_cnt - e0), 64'd1);
        drain("t2", 64'hA0, 1'b0);

        // stalled drain with 1,0,0,1 ready pattern
        send_frame(64'h200, 10, 9);
        check_din("t3_din", 64'h200);
        core_reply(3, 64'hB000_0000_0000_0010);
        drain("t3", 64'hB000_0000_0000_0010, 1'b1);

        // early s_last
        e0 = ena_cnt;
        send_frame(64'h50, 5, 4);
        chk("t4_err_frame", 64'(err_frame), 64'd1);
        chk("t4_s_ready", 64'(s_ready), 64'd1);
        tick();
        chk("t4_err_pulse", 64'(err_frame), 64'd0);
        chk("t4_no_ena", 64'(ena_cnt - e0), 64'd0);
        send_frame(64'h100, 10, 9);
        chk("t4_ena", 64'(core_ena), 64'd1);
        check_din("t4_din", 64'h100);
        core_reply(2, 64'hC0);
        drain("t4", 64'hC0, 1'b0);
        // missing s_last on word 9
        e0 = ena_cnt;
        send_frame(64'h300, 10, -1);
        chk("t4b_err_frame", 64'(err_frame), 64'd1);
        tick();
        chk("t4b_no_ena", 64'(ena_cnt - e0), 64'd0);
        chk("t4b_busy", 64'(busy), 64'd0);

        // timeout: err_tmo after 1023 WAIT cycles, one cycle after WAIT cycle 1023
        send_frame(64'h400, 10, 9);
        chk("t5_ena", 64'(core_ena), 64'd1);
        n = 0;
        while (err_tmo !== 1'b1 && n < 1100) begin
            tick();
            n++;
        end
        chk("t5_tmo_cycles", 64'(n), 64'd1024);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_s_ready", 64'(s_ready), 64'd1);
        tick();
        chk("t5_tmo_pulse", 64'(err_tmo), 64'd0);
        core_rdy  = 1'b1;
        core_dout = mk_dig(64'hDEAD);
        tick();
        core_rdy = 1'b0;
        tick();
        chk("t5_late_rdy_valid", 64'(m_valid), 64'd0);
        chk("t5_late_rdy_busy", 64'(busy), 64'd0);

        // core_rdy in WAIT cycle 1023 wins over the timeout
        send_frame(64'h500, 10, 9);
        core_reply(1023, 64'hE0);
        chk("t5b_no_tmo", 64'(err_tmo), 64'd0);
        drain("t5b", 64'hE0, 1'b0);

        // async reset during drain word 3
        send_frame(64'h600, 10, 9);
        core_reply(4, 64'hF0);
        m_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("t6_word3", m_data, 64'hF3);
        rstb = 1'b0;
        #1;
        chk("t6_m_valid", 64'(m_valid), 64'd0);
        chk("t6_m_data", m_data, 64'd0);
        chk("t6_m_last", 64'(m_last), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_s_ready", 64'(s_ready), 64'd0);
        chk("t6_din0", core_din[639 -: 64], 64'd0);
        tick();
        rstb = 1'b1;
        tick();
        chk("t6_s_ready_back", 64'(s_ready), 64'd1);
        send_frame(64'h700, 10, 9);
        chk("t6_ena", 64'(core_ena), 64'd1);
        check_din("t6_din", 64'h700);
        core_reply(5, 64'h70);
        drain("t6", 64'h70, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
